fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the synchronous FIFO's single write port between NUM_REQ requesters. It latches the winning requester's word, issues a single-cycle write, and checks the FIFO's registered wr_ack/overflow response. It retries overflowed writes up to MAX_RETRY times and completes each transaction with a done or drop pulse. It sits between the requester agents and the FIFO write side inside the FIFO test environment.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  // Index width is sized for the largest supported requester count
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    BACKOFF
  } arb_state_e;

  // Convert a one-hot vector to its bit index; zero when no bit is set
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
module rr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  logic found;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and take the first active request
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_i[j] && (((int'(ptr_i) + k) % NUM_REQ) == j)) begin
          winner_o[j] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port with retry on overflow
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            drop,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          busy,
  output logic                          err
);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      ptr_d;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    win;
  logic                  win_valid;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] win_data;
  logic [2:0]            retry_q;
  logic                  wr_en_q;
  logic                  err_q;
  logic                  resp_ok;
  logic                  resp_bad;
  logic                  retry_left;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .valid_o  (win_valid)
  );

  assign win_idx = onehot_to_idx(MAX_REQ'(win));

  // Pick the winning requester's word out of the packed data bus
  always_comb begin
    win_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win[j]) win_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Only a lone ack is a clean success; ack+overflow or silence is a protocol error
  assign resp_ok    = fifo_wr_ack & ~fifo_overflow;
  assign resp_bad   = (fifo_wr_ack == fifo_overflow);
  assign retry_left = (retry_q < 3'(MAX_RETRY));
  assign ptr_d      = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // Arbitration FSM: grant, issue one write, check response, retry or finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      retry_q <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid && !fifo_full) begin
            idx_q   <= win_idx;
            data_q  <= win_data;
            gnt_q   <= win;
            retry_q <= '0;
            wr_en_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wr_en_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (resp_bad) err_q <= 1'b1;
          if (resp_ok) begin
            ptr_q   <= ptr_d;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else if (retry_left) begin
            retry_q <= retry_q + 3'd1;
            state_q <= BACKOFF;
          end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        BACKOFF: begin
          if (!fifo_full) begin
            wr_en_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion pulses are decided in the response cycle itself
  always_comb begin
    done = '0;
    drop = '0;
    if (state_q == WAIT) begin
      if (resp_ok) done = gnt_q;
      else if (!retry_left) drop = gnt_q;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

endmodule
